msg_schedule_unit: RTL and testbench

- Sits between message_controller and the SHA-256 compression rounds.
- For one 512-bit block it fetches 16 big-endian 32-bit words over the controller's req_word/word_address/word_valid interface.
- It then streams the 64 schedule words W[0..63], one per handshake, to the round logic.
- A 16-entry sliding window computes W[t+16] on the fly; no 64-word storage is used.

---
 rtl/msg_schedule_unit.sv | 142 ++++++++++++++
 tb/tb_msg_schedule_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule_unit.sv
// rtl/msg_schedule_unit.sv - SHA-256 message schedule: fetches 16 words, streams W[0..63] via a 16-word window.
// Optional MSG_SCHED_BSWAP_EN: byte-reverse each fetched word before capture.
module msg_schedule_unit #(
  parameter int ADDR_W = 8,
  parameter int BLK_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BLK_W-1:0]  block_idx,
  output logic              req_word,
  output logic [ADDR_W-1:0] word_address,
  input  logic [31:0]       word_data,
  input  logic              word_valid,
  output logic [31:0]       w_out,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [5:0]        round_idx,
  output logic              busy,
  output logic              block_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int SUM_W = (ADDR_W > BLK_W + 4) ? ADDR_W : BLK_W + 4;

  state_t            state;
  state_t            state_nxt;
  logic [BLK_W-1:0]  blk;
  logic [3:0]        fetch_cnt;
  logic [5:0]        t;
  logic [31:0]       win [16];
  logic [31:0]       cap_word;
  logic [31:0]       new_word;
  logic [SUM_W-1:0]  addr_full;
  logic              fetch_acc;
  logic              w_hs;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef MSG_SCHED_BSWAP_EN
  assign cap_word = {word_data[7:0], word_data[15:8], word_data[23:16], word_data[31:24]};
`else
  assign cap_word = word_data;
`endif

  // fetch_cnt < 16, so {blk,4'b0}+i is just the concatenation; wraps at ADDR_W.
  assign addr_full = SUM_W'({blk, fetch_cnt});
  assign fetch_acc = (state == S_FETCH) && word_valid;
  assign w_hs      = (state == S_EXPAND) && w_ready;
  assign new_word  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (fetch_acc && fetch_cnt == 4'd15) state_nxt = S_EXPAND;
      S_EXPAND: if (w_hs && t == 6'd63) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_word     = 1'b0;
    word_address = '0;
    w_valid      = 1'b0;
    w_out        = '0;
    round_idx    = '0;
    busy         = 1'b0;
    block_done   = 1'b0;
    case (state)
      S_FETCH: begin
        req_word     = 1'b1;
        word_address = addr_full[ADDR_W-1:0];
        busy         = 1'b1;
      end
      S_EXPAND: begin
        w_valid   = 1'b1;
        w_out     = win[0];
        round_idx = t;
        busy      = 1'b1;
      end
      S_DONE:  block_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk       <= '0;
      fetch_cnt <= '0;
      t         <= '0;
      for (int k = 0; k < 16; k++) win[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            blk       <= block_idx;
            fetch_cnt <= '0;
            t         <= '0;
          end
        end
        S_FETCH: begin
          if (fetch_acc) begin
            win[fetch_cnt] <= cap_word;
            fetch_cnt      <= fetch_cnt + 4'd1;
          end
        end
        S_EXPAND: begin
          // Window slides by one; W[t+16] enters at the top (junk past t=47 is never read).
          if (w_hs) begin
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= new_word;
            t       <= t + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_schedule_unit.sv
// tb/tb_msg_schedule_unit.sv - scoreboard bench for msg_schedule_unit.
module tb_msg_schedule_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  block_idx = '0;
  logic        req_word;
  logic [7:0]  word_address;
  logic [31:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic [31:0] w_out;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [5:0]  round_idx;
  logic        busy;
  logic        block_done;

  int tests = 0;
  int fails = 0;

  logic [31:0] lm  [256];
  logic [31:0] mem [256];
  logic [31:0] ws  [64];
  logic [31:0] sb  [$];

  msg_schedule_unit #(.ADDR_W(8), .BLK_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .block_idx(block_idx),
    .req_word(req_word), .word_address(word_address), .word_data(word_data),
    .word_valid(word_valid), .w_out(w_out), .w_valid(w_valid), .w_ready(w_ready),
    .round_idx(round_idx), .busy(busy), .block_done(block_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    lm[a] = w;
`ifdef MSG_SCHED_BSWAP_EN
    mem[a] = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    mem[a] = w;
`endif
  endtask

  task automatic load_abc(input int blk);
    for (int k = 0; k < 16; k++) put_word(blk * 16 + k, 32'h0);
    put_word(blk * 16, 32'h61626380);
    put_word(blk * 16 + 15, 32'h00000018);
  endtask

  task automatic load_rand(input int blk);
    for (int k = 0; k < 16; k++) put_word(blk * 16 + k, $urandom);
  endtask

  task automatic compute_sched(input int blk);
    for (int k = 0; k < 16; k++) ws[k] = lm[blk * 16 + k];
    for (int k = 16; k < 64; k++) ws[k] = ss1(ws[k-2]) + ws[k-7] + ss0(ws[k-15]) + ws[k-16];
    sb.delete();
    for (int k = 0; k < 64; k++) sb.push_back(ws[k]);
  endtask

  task automatic run_block(input logic [3:0] blk, input bit alt_valid, input int stall_t,
                           input int rst_t, input int exp_first, input int exp_done, input bit chk_abc);
    int fi, hs, stall_left, cyc;
    bit done_seen, first_seen;
    compute_sched(int'(blk));
    @(negedge clk);
    block_idx = blk;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    block_idx = blk + 4'd5;
    fi = 0; hs = 0; stall_left = 5; cyc = 1;
    done_seen = 1'b0; first_seen = 1'b0;
    while (cyc < 400 && !done_seen) begin
      @(negedge clk);
      start = 1'b0;
      w_ready = 1'b1;
      if (fi < 16) begin
        chk("req_word_fetch", req_word, 1);
        chk("word_address", word_address, {blk, fi[3:0]});
        word_valid = alt_valid ? cyc[0] : 1'b1;
        word_data = mem[word_address];
        if (word_valid) fi++;
      end else begin
        word_valid = !alt_valid;
        word_data = 32'hDEADBEEF;
      end
      if (w_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          if (exp_first >= 0) chk("first_w_valid_cycle", cyc, exp_first);
        end
        if (hs == rst_t) begin
          w_ready = 1'b0;
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          @(negedge clk);
          chk("rst_busy", busy, 0);
          chk("rst_w_valid", w_valid, 0);
          chk("rst_round_idx", round_idx, 0);
          chk("rst_req_word", req_word, 0);
          return;
        end
        if (sb.size() == 0) begin
          chk("hs_count_le_63", hs, 63);
        end else begin
          chk("round_idx", round_idx, hs);
          chk("w_out", w_out, sb[0]);
          if (hs == 10 && stall_t >= 0) begin
            start = 1'b1;
            block_idx = 4'hA;
          end
          if (hs == stall_t && stall_left > 0) begin
            w_ready = 1'b0;
            stall_left--;
          end else begin
            if (chk_abc) begin
              if (hs == 0)  chk("abc_W0",  w_out, 32'h61626380);
              if (hs == 15) chk("abc_W15", w_out, 32'h00000018);
              if (hs == 16) chk("abc_W16", w_out, 32'h61626380);
              if (hs == 17) chk("abc_W17", w_out, 32'h000F0000);
              if (hs == 63) chk("abc_W63", w_out, 32'h12B1EDEB);
            end
            void'(sb.pop_front());
            hs++;
          end
        end
      end
      if (block_done) begin
        done_seen = 1'b1;
        chk("done_hs_count", hs, 64);
        chk("done_busy", busy, 0);
        chk("done_w_valid", w_valid, 0);
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        if (stall_t >= 0) start = 1'b1;
      end
      cyc++;
    end
    chk("block_done_seen", done_seen, 1);
    @(negedge clk);
    start = 1'b0;
    chk("done_single_pulse", block_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_req_word", req_word, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_word", req_word, 0);
    chk("reset_w_valid", w_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_block_done", block_done, 0);
    chk("reset_word_address", word_address, 0);
    chk("reset_round_idx", round_idx, 0);
    chk("reset_w_out", w_out, 0);
    rst = 1'b0;

    load_abc(0);
    run_block(4'd0, 1'b0, -1, -1, 17, 81, 1'b1);

    load_rand(3);
    run_block(4'd3, 1'b0, -1, -1, 17, 81, 1'b0);

    run_block(4'd0, 1'b1, -1, -1, -1, -1, 1'b1);

    load_rand(5);
    run_block(4'd5, 1'b0, 20, -1, 17, 86, 1'b0);

    load_rand(2);
    run_block(4'd2, 1'b0, -1, 30, 17, -1, 1'b0);
    run_block(4'd2, 1'b0, -1, -1, 17, 81, 1'b0);

    load_abc(15);
    run_block(4'd15, 1'b0, -1, -1, 17, 81, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
